// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 device-side responder: command classes,
// data-command bit positions, FSM state encoding and the key-scan byte layout.
package tm1638_pkg;

    localparam logic [1:0] CLS_DATA = 2'b01;
    localparam logic [1:0] CLS_DISP = 2'b10;
    localparam logic [1:0] CLS_ADDR = 2'b11;

    localparam int READ_BIT  = 1;
    localparam int FIXED_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RDATA  = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

    // Read byte i carries two keys: bit0 = keys[7-i], bit4 = keys[3-i].
    function automatic logic [7:0] key_byte(input logic [7:0] k, input logic [2:0] idx);
        case (idx)
            3'd0:    key_byte = {3'b000, k[3], 3'b000, k[7]};
            3'd1:    key_byte = {3'b000, k[2], 3'b000, k[6]};
            3'd2:    key_byte = {3'b000, k[1], 3'b000, k[5]};
            3'd3:    key_byte = {3'b000, k[0], 3'b000, k[4]};
            default: key_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/tm1638_responder_if.sv
// Three-wire TM1638 host bus. The host (master) drives STB/CLK and the DIO pad
// input; the responder (slave) returns a DIO drive value and its enable.
interface tm1638_responder_if;
    logic stb;
    logic sclk;
    logic dio_in;
    logic dio_out;
    logic dio_oe;

    modport master (output stb, output sclk, output dio_in, input dio_out, input dio_oe);
    modport slave  (input stb, input sclk, input dio_in, output dio_out, output dio_oe);
endinterface

// File: rtl/tm1638_pin_sync.sv
// Two-stage synchronizers for the asynchronous host pins plus a history stage
// used for edge detection. Edge strobes are registered, so a pin edge shows up
// as a strobe three clk cycles later; dio is delayed to line up with them.
module tm1638_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic sclk,
    input  logic dio_in,
    output logic stb_fall,
    output logic stb_rise,
    output logic sclk_fall,
    output logic sclk_rise,
    output logic dio
);
    // [0] first sync stage, [1] second sync stage, [2] previous synchronized value
    logic [2:0] stb_q, stb_d, sclk_q, sclk_d, dio_q, dio_d;
    logic [3:0] edge_q, edge_d;

    // Next values of the sync chains and the edge strobes.
    always_comb begin
        stb_d  = {stb_q[1:0], stb};
        sclk_d = {sclk_q[1:0], sclk};
        dio_d  = {dio_q[1:0], dio_in};
        edge_d = {~stb_q[1] & stb_q[2], stb_q[1] & ~stb_q[2],
                  ~sclk_q[1] & sclk_q[2], sclk_q[1] & ~sclk_q[2]};
    end

    // Sync/edge registers; STB and CLK idle high so reset to 1 to avoid false edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q  <= 3'b111;
            sclk_q <= 3'b111;
            dio_q  <= 3'b000;
            edge_q <= 4'b0000;
        end else begin
            stb_q  <= stb_d;
            sclk_q <= sclk_d;
            dio_q  <= dio_d;
            edge_q <= edge_d;
        end
    end

    assign stb_fall  = edge_q[3];
    assign stb_rise  = edge_q[2];
    assign sclk_fall = edge_q[1];
    assign sclk_rise = edge_q[0];
    assign dio       = dio_q[2];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes host commands, holds the 16-byte
// display RAM and display-control state, and returns key-scan bytes on reads.
// Optional feature macro: TM1638_RESPONDER_KEYSCAN_EN enables read-back of
// keys; without it a read command is reported via cmd_err and DIO is never driven.
module tm1638_responder
    import tm1638_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    tm1638_responder_if.slave        bus,
    input  logic [7:0]               keys,
    output logic [127:0]             disp_ram,
    output logic                     display_on,
    output logic [2:0]               display_level,
    output logic                     frame_done,
    output logic                     cmd_err
);
    logic stb_fall, stb_rise, sclk_fall, sclk_rise, dio_s;

    tm1638_pin_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .stb       (bus.stb),
        .sclk      (bus.sclk),
        .dio_in    (bus.dio_in),
        .stb_fall  (stb_fall),
        .stb_rise  (stb_rise),
        .sclk_fall (sclk_fall),
        .sclk_rise (sclk_rise),
        .dio       (dio_s)
    );

    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     shreg_q, shreg_d;
    logic [3:0]     addr_q, addr_d;
    logic           fixed_q, fixed_d;
    logic [127:0]   ram_q, ram_d;
    logic           on_q, on_d;
    logic [2:0]     level_q, level_d;
    logic           frame_done_q, frame_done_d;
    logic           cmd_err_q, cmd_err_d;
    logic [7:0]     byte_nxt;
`ifdef TM1638_RESPONDER_KEYSCAN_EN
    logic [2:0]     rd_idx_q, rd_idx_d;
    logic [7:0]     rd_byte_q, rd_byte_d;
    logic           dio_out_q, dio_out_d;
    logic           dio_oe_q, dio_oe_d;
    logic [7:0]     key_b;
`endif

    // Frame/command FSM, byte assembly, RAM writes and read-bit drive.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        addr_d       = addr_q;
        fixed_d      = fixed_q;
        ram_d        = ram_q;
        on_d         = on_q;
        level_d      = level_q;
        frame_done_d = 1'b0;
        cmd_err_d    = 1'b0;
        byte_nxt     = {dio_s, shreg_q};
`ifdef TM1638_RESPONDER_KEYSCAN_EN
        rd_idx_d     = rd_idx_q;
        rd_byte_d    = rd_byte_q;
        dio_out_d    = dio_out_q;
        dio_oe_d     = dio_oe_q;
        key_b        = key_byte(keys, rd_idx_q);
`endif
        if (stb_rise) begin
            // STB high ends the frame from any state; a partial byte is dropped.
            state_d      = ST_IDLE;
            bit_cnt_d    = 3'd0;
            frame_done_d = 1'b1;
`ifdef TM1638_RESPONDER_KEYSCAN_EN
            dio_oe_d     = 1'b0;
`endif
        end else if (stb_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
        end else begin
            if (sclk_rise && state_q != ST_IDLE) begin
                shreg_d   = byte_nxt[7:1];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        ST_CMD: begin
                            state_d = ST_IGNORE;
                            case (byte_nxt[7:6])
                                CLS_DATA: begin
                                    fixed_d = byte_nxt[FIXED_BIT];
                                    if (byte_nxt[READ_BIT]) begin
`ifdef TM1638_RESPONDER_KEYSCAN_EN
                                        state_d  = ST_RDATA;
                                        rd_idx_d = 3'd0;
`else
                                        cmd_err_d = 1'b1;
`endif
                                    end
                                end
                                CLS_ADDR: begin
                                    addr_d  = byte_nxt[3:0];
                                    state_d = ST_WDATA;
                                end
                                CLS_DISP: begin
                                    on_d    = byte_nxt[3];
                                    level_d = byte_nxt[2:0];
                                end
                                default: cmd_err_d = 1'b1;
                            endcase
                        end
                        ST_WDATA: begin
                            ram_d[{addr_q, 3'b000} +: 8] = byte_nxt;
                            if (!fixed_q) addr_d = addr_q + 4'd1;
                        end
`ifdef TM1638_RESPONDER_KEYSCAN_EN
                        ST_RDATA: begin
                            if (rd_idx_q < 3'd4) rd_idx_d = rd_idx_q + 3'd1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef TM1638_RESPONDER_KEYSCAN_EN
            // Drive read bit k on the host falling edge; keys captured at bit 0.
            if (sclk_fall && state_q == ST_RDATA) begin
                dio_oe_d = 1'b1;
                if (bit_cnt_q == 3'd0) begin
                    rd_byte_d = key_b;
                    dio_out_d = key_b[0];
                end else begin
                    dio_out_d = rd_byte_q[bit_cnt_q];
                end
            end
`endif
        end
    end

    // State register; every bit including the display RAM clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 7'd0;
            addr_q       <= 4'd0;
            fixed_q      <= 1'b0;
            ram_q        <= '0;
            on_q         <= 1'b0;
            level_q      <= 3'd0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
`ifdef TM1638_RESPONDER_KEYSCAN_EN
            rd_idx_q     <= 3'd0;
            rd_byte_q    <= 8'd0;
            dio_out_q    <= 1'b0;
            dio_oe_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            addr_q       <= addr_d;
            fixed_q      <= fixed_d;
            ram_q        <= ram_d;
            on_q         <= on_d;
            level_q      <= level_d;
            frame_done_q <= frame_done_d;
            cmd_err_q    <= cmd_err_d;
`ifdef TM1638_RESPONDER_KEYSCAN_EN
            rd_idx_q     <= rd_idx_d;
            rd_byte_q    <= rd_byte_d;
            dio_out_q    <= dio_out_d;
            dio_oe_q     <= dio_oe_d;
`endif
        end
    end

`ifdef TM1638_RESPONDER_KEYSCAN_EN
    assign bus.dio_out = dio_out_q;
    assign bus.dio_oe  = dio_oe_q;
`else
    logic unused_keyscan;
    assign unused_keyscan = ^{keys, sclk_fall};
    assign bus.dio_out    = 1'b0;
    assign bus.dio_oe     = 1'b0;
`endif

    assign disp_ram      = ram_q;
    assign display_on    = on_q;
    assign display_level = level_q;
    assign frame_done    = frame_done_q;
    assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: directed test-plan frames plus randomized frames,
// checked against a byte-level model of the TM1638 command set.
module tb_tm1638_responder;
    localparam int H = 6; // host half-period in clk cycles (12x ratio)

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   keys = 8'h00;
    logic [127:0] disp_ram;
    logic         display_on;
    logic [2:0]   display_level;
    logic         frame_done;
    logic         cmd_err;

    tm1638_responder_if bus ();

    tm1638_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .keys          (keys),
        .disp_ram      (disp_ram),
        .display_on    (display_on),
        .display_level (display_level),
        .frame_done    (frame_done),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (cmd_err) err_cnt++;
    end

    // model state
    logic [7:0] m_ram [16];
    logic       m_fixed;
    logic       m_on;
    logic [2:0] m_lvl;
    int         m_err;
    int         m_frames;
    logic [7:0] tx_q [$];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_ram();
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = m_ram[n];
        return r;
    endfunction

    function automatic logic [7:0] model_key(input logic [7:0] k, input int i);
        if (i >= 4) return 8'h00;
        return 8'(((k >> (7 - i)) & 8'h1) | (((k >> (3 - i)) & 8'h1) << 4));
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 16; n++) m_ram[n] = 8'h00;
        m_fixed = 1'b0;
        m_on    = 1'b0;
        m_lvl   = 3'd0;
    endtask

    // apply one complete frame held in tx_q to the model
    task automatic model_frame();
        logic [7:0] c;
        logic [3:0] a;
        c = tx_q[0];
        case (c[7:6])
            2'b01: begin
                m_fixed = c[2];
`ifndef TM1638_RESPONDER_KEYSCAN_EN
                if (c[1]) m_err++;
`endif
            end
            2'b11: begin
                a = c[3:0];
                for (int j = 1; j < tx_q.size(); j++) begin
                    m_ram[a] = tx_q[j];
                    if (!m_fixed) a = a + 4'd1;
                end
            end
            2'b10: begin
                m_on  = c[3];
                m_lvl = c[2:0];
            end
            default: m_err++;
        endcase
        m_frames++;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin();
        bus.stb = 1'b0;
        wait_clk(H);
    endtask

    task automatic frame_end();
        bus.stb = 1'b0;
        bus.stb = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.sclk   = 1'b0;
            bus.dio_in = b[i];
            wait_clk(H);
            bus.sclk   = 1'b1;
            wait_clk(H);
        end
    endtask

    task automatic read_byte(output logic [7:0] rb, output logic oe_all, output logic oe_any);
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.sclk = 1'b0;
            wait_clk(H);
            rb[i]  = bus.dio_out;
            oe_all = oe_all & bus.dio_oe;
            oe_any = oe_any | bus.dio_oe;
            bus.sclk = 1'b1;
            wait_clk(H);
        end
    endtask

    // send tx_q as one frame and update the model
    task automatic run_frame();
        frame_begin();
        foreach (tx_q[j]) send_bits(tx_q[j], 8);
        frame_end();
        model_frame();
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_ram"}, disp_ram, model_ram());
        check_val({tag, "_disp"}, {display_on, display_level}, {m_on, m_lvl});
        check_val({tag, "_err"}, err_cnt, m_err);
        check_val({tag, "_frames"}, fd_cnt, m_frames);
    endtask

    // read frame: command 0x42, then nb read bytes with keys = k
    task automatic run_read(input string tag, input logic [7:0] k, input int nb);
        logic [7:0] rb;
        logic oe_all, oe_any;
        keys = k;
        tx_q = {8'h42};
        frame_begin();
        send_bits(8'h42, 8);
        for (int i = 0; i < nb; i++) begin
            read_byte(rb, oe_all, oe_any);
`ifdef TM1638_RESPONDER_KEYSCAN_EN
            check_val({tag, "_byte"}, rb, model_key(k, i));
            check_val({tag, "_oe"}, oe_all, 1'b1);
`else
            check_val({tag, "_oe_off"}, oe_any, 1'b0);
`endif
        end
        bus.stb = 1'b1;
        wait_clk(4);
        check_val({tag, "_oe_release"}, bus.dio_oe, 1'b0);
        wait_clk(6);
        model_frame();
    endtask

    logic [127:0] snap;
    int fd0, err0;
    int kind, nb;

    initial begin
        bus.stb = 1'b1;
        bus.sclk = 1'b1;
        bus.dio_in = 1'b0;
        m_err = 0;
        m_frames = 0;
        model_reset();
        wait_clk(3);
        check_val("reset_ram", disp_ram, 128'd0);
        check_val("reset_outs", {display_on, display_level, frame_done, cmd_err, bus.dio_oe, bus.dio_out}, 8'd0);
        rst_n = 1'b1;
        wait_clk(5);
        check_val("post_reset_outs", {display_on, display_level, frame_done, cmd_err, bus.dio_oe}, 7'd0);

        // auto-increment write
        fd0 = fd_cnt;
        tx_q = {8'h40}; run_frame();
        tx_q = {8'hC0, 8'h3F, 8'h06, 8'h5B}; run_frame();
        check_val("autoinc_bytes", disp_ram[23:0], 24'h5B063F);
        check_val("autoinc_fd", fd_cnt - fd0, 2);
        check_all("autoinc");

        // wrap 15 -> 0
        tx_q = {8'hCF, 8'hAA, 8'hBB}; run_frame();
        check_val("wrap_b15", disp_ram[127:120], 8'hAA);
        check_val("wrap_b0", disp_ram[7:0], 8'hBB);
        check_all("wrap");

        // fixed address
        tx_q = {8'h44}; run_frame();
        tx_q = {8'hC3, 8'h11, 8'h22}; run_frame();
        check_val("fixed_b3", disp_ram[31:24], 8'h22);
        check_val("fixed_b4", disp_ram[39:32], 8'h00);
        check_all("fixed");
        tx_q = {8'h40}; run_frame();

        // display control
        tx_q = {8'h8B}; run_frame();
        check_val("disp_on", display_on, 1'b1);
        check_val("disp_lvl", display_level, 3'd3);
        check_all("disp");

        // key read
        run_read("keyrd", 8'b1000_0001, 4);
        check_all("keyrd");
        run_read("keyrd5", 8'($urandom), 5);
        check_all("keyrd5");

        // abort mid byte
        snap = disp_ram;
        frame_begin();
        send_bits(8'hC5, 8);
        send_bits(8'hEE, 5);
        frame_end();
        tx_q = {8'hC5}; model_frame();
        check_val("abort_ram", disp_ram, snap);
        check_all("abort");

        // undecodable command
        snap = disp_ram;
        err0 = err_cnt;
        tx_q = {8'h05}; run_frame();
        check_val("err_pulse", err_cnt - err0, 1);
        check_val("err_ram", disp_ram, snap);
        check_all("err");

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: begin tx_q = {8'h40 | 8'($urandom_range(0, 3) << 2)}; run_frame(); end
                1: begin
                    tx_q = {8'hC0 | 8'($urandom_range(0, 15))};
                    nb = int'($urandom_range(1, 5));
                    for (int j = 0; j < nb; j++) tx_q.push_back(8'($urandom));
                    run_frame();
                end
                2: begin tx_q = {8'h80 | 8'($urandom_range(0, 63))}; run_frame(); end
                3: begin tx_q = {8'($urandom_range(0, 63))}; run_frame(); end
                default: run_read("rnd_rd", 8'($urandom), int'($urandom_range(1, 5)));
            endcase
            check_all("rnd");
        end

        // asynchronous reset in the middle of a write frame
        tx_q = {8'h40}; run_frame();
        frame_begin();
        send_bits(8'hC2, 8);
        send_bits(8'h77, 8);
        send_bits(8'h99, 3);
        #2 rst_n = 1'b0;
        #1 check_val("midrst_ram", disp_ram, 128'd0);
        check_val("midrst_disp", {display_on, display_level}, 4'd0);
        bus.stb = 1'b1;
        bus.sclk = 1'b1;
        model_reset();
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(8);
        tx_q = {8'hC1, 8'h12, 8'h34}; run_frame();
        check_all("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
